// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
// Module   : router_fsm
// Purpose  : Input-side packet sequencer for the 1x3 router (Moore FSM).
// Revision : 1.0
// ============================================================================
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic [1:0] w_addr;
  logic       w_sel_empty;
  logic       w_soft;
  logic       w_addr_ok;

  assign w_addr_ok = pkt_valid && (data_in != 2'd3);

  // In DA the address is still on the bus; afterwards it lives in r_addr.
  assign w_addr = (r_state == DA) ? data_in : r_addr;

  always_comb begin
    w_sel_empty = 1'b0;
    w_soft      = 1'b0;
    case (w_addr)
      2'd0:    w_sel_empty = fifo_empty_0;
      2'd1:    w_sel_empty = fifo_empty_1;
      2'd2:    w_sel_empty = fifo_empty_2;
      default: w_sel_empty = 1'b0;
    endcase
    case (r_addr)
      2'd0:    w_soft = soft_reset_0;
      2'd1:    w_soft = soft_reset_1;
      2'd2:    w_soft = soft_reset_2;
      default: w_soft = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if ((r_state != DA) && w_soft) begin
      w_next = DA;
    end else begin
      case (r_state)
        DA:  if (w_addr_ok) w_next = w_sel_empty ? LFD : WTE;
        WTE: if (w_sel_empty) w_next = LFD;
        LFD: w_next = LD;
        LD: begin
          if (fifo_full)       w_next = FFS;
          else if (!pkt_valid) w_next = LP;
        end
        FFS: if (!fifo_full) w_next = LAF;
        LAF: begin
          if (parity_done)        w_next = DA;
          else if (low_pkt_valid) w_next = LP;
          else                    w_next = LD;
        end
        LP:  w_next = CPE;
        CPE: w_next = fifo_full ? FFS : DA;
        default: w_next = DA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= DA;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == DA) && w_addr_ok) r_addr <= data_in;
    end
  end

  assign detect_add    = (r_state == DA);
  assign lfd_state     = (r_state == LFD);
  assign ld_state      = (r_state == LD);
  assign full_state    = (r_state == FFS);
  assign laf_state     = (r_state == LAF);
  assign rst_int_reg   = (r_state == CPE);
  assign write_enb_reg = (r_state == LD) || (r_state == LP) || (r_state == LAF);
  assign busy          = (r_state != DA) && (r_state != LD);

endmodule
`default_nettype wire

// File: doc/router_fsm.md
# router_fsm

Packet-control state machine for the 1x3 router's input side. It sits directly upstream of `router_sync` and sequences each incoming packet through header decode, payload load, full-stall, parity load and parity check. It drives `detect_add` and `write_enb_reg` into `router_sync`, and takes `fifo_full` and `soft_reset_0..2` back from it.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  synchronous, active-low reset.
- `pkt_valid`  in  1  a packet byte is present on the input bus.
- `data_in`  in  2  header address bits [1:0]: 0, 1 or 2 selects the FIFO; 3 is invalid.
- `parity_done`  in  1  the register block has captured the parity byte.
- `low_pkt_valid`  in  1  `pkt_valid` fell while the block was stalled on full.
- `fifo_full`  in  1  the selected FIFO is full.
- `fifo_empty_0/1/2`  in  1 each  empty flag of each output FIFO.
- `soft_reset_0/1/2`  in  1 each  per-FIFO timeout reset.
- `detect_add`  out  1  state is DECODE_ADDRESS.
- `lfd_state`  out  1  state is LOAD_FIRST_DATA.
- `ld_state`  out  1  state is LOAD_DATA.
- `full_state`  out  1  state is FIFO_FULL_STATE.
- `laf_state`  out  1  state is LOAD_AFTER_FULL.
- `rst_int_reg`  out  1  state is CHECK_PARITY_ERROR.
- `write_enb_reg`  out  1  true in LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
- `busy`  out  1  true in every state except DECODE_ADDRESS and LOAD_DATA.

## Operation
The block has 8 states: DA (DECODE_ADDRESS), LFD, LD, FFS, LAF, LP (LOAD_PARITY), CPE (CHECK_PARITY_ERROR) and WTE (WAIT_TILL_EMPTY).

- **Address register.** A 2-bit `addr_q` loads `data_in` whenever state=DA and `pkt_valid`=1 and `data_in`!=3. It holds otherwise. Reset value is 0.
- **Selected empty flag.** `sel_empty` is `fifo_empty_[addr]`. In DA, `addr` is `data_in`. In every other state, `addr` is `addr_q`.

Next-state priority, highest first:
1. `resetn`=0 -> DA.
2. `soft_reset_[addr_q]`=1 while state!=DA -> DA.
3. The transition table below.

Transitions:
- **DA:**
  - `pkt_valid`=1, `data_in`<3, `sel_empty`=1 -> LFD.
  - `pkt_valid`=1, `data_in`<3, `sel_empty`=0 -> WTE.
  - Otherwise stay in DA. `data_in`=3 is dropped.
- **WTE:** `sel_empty`=1 -> LFD; else stay.
- **LFD:** unconditionally -> LD.
- **LD:** `fifo_full`=1 -> FFS; else `pkt_valid`=0 -> LP; else stay.
- **FFS:** `fifo_full`=0 -> LAF; else stay.
- **LAF:**
  - `parity_done`=1 -> DA.
  - `parity_done`=0 and `low_pkt_valid`=1 -> LP.
  - `parity_done`=0 and `low_pkt_valid`=0 -> LD.
- **LP:** unconditionally -> CPE.
- **CPE:** `fifo_full`=1 -> FFS; else -> DA.

All outputs are pure decodes of the state register (Moore); there is no output logic on the input path.

## Timing
- State and `addr_q` update on the rising edge of `clk`. Outputs change in the same cycle as the state, i.e. one clock after the inputs that caused the transition were sampled.
- Reset values: state=DA, `detect_add`=1, and every other output 0 (including `busy` and `write_enb_reg`). `addr_q`=0.
- Minimum packet path DA->LFD->LD->LP->CPE->DA takes 4 cycles of overhead plus the payload cycles in LD.
- `write_enb_reg` and `busy` are never both low outside DA and LD. The input bus must be held while `busy`=1.
- **Soft reset mid-packet:** returns the block to DA on the next edge, from any state. An unselected `soft_reset_x` is ignored.
- **`fifo_full` in LFD:** ignored; LFD always advances to LD.
- **Simultaneous `fifo_full`=1 and `pkt_valid`=0 in LD:** FFS wins.
- **`pkt_valid` dropping in FFS:** no effect; it is reported via `low_pkt_valid` and acted on in LAF.

## Test plan
- **Hard reset:** `resetn`=0 for 1 edge -> `detect_add`=1, `busy`=0, `write_enb_reg`=0; `addr_q`=0.
- **Normal packet:** `pkt_valid`=1, `data_in`=2, `fifo_empty_2`=1; hold `pkt_valid` 3 cycles after LFD, then drop it; `fifo_full`=0.
  - State sequence: DA, LFD, LD, LD, LD, LP, CPE, DA.
  - `lfd_state` high for 1 cycle; `write_enb_reg` high for 4 cycles (LD x3, LP); `rst_int_reg` high for 1 cycle.
- **Full stall:** in LD, assert `fifo_full` for 3 cycles with `parity_done`=0 and `low_pkt_valid`=0.
  - Expect FFS with `full_state`=1 and `busy`=1 for 3 cycles, then LAF for 1 cycle, then LD.
  - Repeat with `low_pkt_valid`=1 -> LAF then LP.
  - Repeat with `parity_done`=1 -> LAF then DA.
- **Busy destination:** `data_in`=1, `fifo_empty_1`=0 -> WTE with `busy`=1. Raise `fifo_empty_1` after 5 cycles -> LFD on the next edge. `data_in`=3 with `pkt_valid`=1 -> stays in DA.
- **Soft reset:** packet to addr 0 stalled in FFS.
  - Pulse `soft_reset_1` -> no change.
  - Pulse `soft_reset_0` -> DA on the next edge with `detect_add`=1.
  - Also pulse `soft_reset_0` in WTE -> DA.
- **Reset mid-packet:** `resetn`=0 while in LD -> DA on the next edge, `write_enb_reg`=0.
